// File: rtl/psr_cond_unit.sv
// Processor status register behind the ALU: masked flag capture, carry feedback,
// and registered branch-condition evaluation against the PSR value being written.
module psr_cond_unit #(
  parameter int NFLAGS = 5,
  parameter int CONDW  = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              carry_i,
  input  logic              low_i,
  input  logic              overflow_i,
  input  logic              zero_i,
  input  logic              negative_i,
  input  logic              flag_we_i,
  input  logic [NFLAGS-1:0] flag_mask_i,
  input  logic              psr_load_i,
  input  logic [NFLAGS-1:0] psr_din_i,
  input  logic              cond_valid_i,
  input  logic [CONDW-1:0]  cond_code_i,
  output logic [NFLAGS-1:0] psr_o,
  output logic              carry_q_o,
  output logic              cond_done_o,
  output logic              cond_true_o
);

  localparam int C_IDX = 4;
  localparam int L_IDX = 3;
  localparam int F_IDX = 2;
  localparam int Z_IDX = 1;
  localparam int N_IDX = 0;

  logic [NFLAGS-1:0] psr_q, psr_d;
  logic [NFLAGS-1:0] alu_flags, merged;
  logic              cond_done_q, cond_done_d;
  logic              cond_true_q, cond_true_d;

  assign alu_flags = {carry_i, low_i, overflow_i, zero_i, negative_i};

  for (genvar i = 0; i < NFLAGS; i++) begin : g_flag
    assign merged[i] = flag_mask_i[i] ? alu_flags[i] : psr_q[i];
  end

  // Direct load wins outright; mask bits are never merged into a restore.
  always_comb begin
    psr_d = psr_q;
    if (psr_load_i)     psr_d = psr_din_i;
    else if (flag_we_i) psr_d = merged;
  end

  function automatic logic cond_eval(input logic [CONDW-1:0] code,
                                     input logic [NFLAGS-1:0] f);
    logic r;
    r = 1'b0;
    case (code)
      4'h0: r =  f[Z_IDX];
      4'h1: r = !f[Z_IDX];
      4'h2: r =  f[C_IDX];
      4'h3: r = !f[C_IDX];
      4'h4: r =  f[L_IDX];
      4'h5: r = !f[L_IDX];
      4'h6: r =  f[N_IDX];
      4'h7: r = !f[N_IDX];
      4'h8: r =  f[F_IDX];
      4'h9: r = !f[F_IDX];
      4'hA: r = !f[L_IDX] && !f[Z_IDX];
      4'hB: r =  f[L_IDX] ||  f[Z_IDX];
      4'hC: r = !f[N_IDX] && !f[Z_IDX];
      4'hD: r =  f[N_IDX] ||  f[Z_IDX];
      4'hE: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Evaluate against psr_d so a flag-setting op and its branch can share a cycle.
  always_comb begin
    cond_done_d = cond_valid_i;
    cond_true_d = cond_true_q;
    if (cond_valid_i) cond_true_d = cond_eval(cond_code_i, psr_d);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      psr_q       <= '0;
      cond_done_q <= 1'b0;
      cond_true_q <= 1'b0;
    end else begin
      psr_q       <= psr_d;
      cond_done_q <= cond_done_d;
      cond_true_q <= cond_true_d;
    end
  end

  assign psr_o       = psr_q;
  assign carry_q_o   = psr_q[C_IDX];
  assign cond_done_o = cond_done_q;
  assign cond_true_o = cond_true_q;

endmodule

// File: tb/tb_psr_cond_unit.sv
// Bench for psr_cond_unit: directed scenarios plus a random run, with condition
// results checked through a scoreboard queue drained by a negedge monitor.
module tb_psr_cond_unit;

  logic       clk_i = 1'b0;
  logic       reset_i, carry_i, low_i, overflow_i, zero_i, negative_i;
  logic       flag_we_i, psr_load_i, cond_valid_i;
  logic [4:0] flag_mask_i, psr_din_i;
  logic [3:0] cond_code_i;
  logic [4:0] psr_o;
  logic       carry_q_o, cond_done_o, cond_true_o;

  int   errors = 0;
  int   checks = 0;
  bit   sb_q[$];
  logic [4:0] psr_m = 5'b0;

  psr_cond_unit dut (
    .clk_i(clk_i), .reset_i(reset_i), .carry_i(carry_i), .low_i(low_i),
    .overflow_i(overflow_i), .zero_i(zero_i), .negative_i(negative_i),
    .flag_we_i(flag_we_i), .flag_mask_i(flag_mask_i), .psr_load_i(psr_load_i),
    .psr_din_i(psr_din_i), .cond_valid_i(cond_valid_i), .cond_code_i(cond_code_i),
    .psr_o(psr_o), .carry_q_o(carry_q_o), .cond_done_o(cond_done_o),
    .cond_true_o(cond_true_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference condition table, written directly from named flags.
  function automatic bit ref_cond(input logic [3:0] code, input logic [4:0] f);
    bit c, l, fl, z, n;
    {c, l, fl, z, n} = f;
    case (code)
      4'd0:  return z;        4'd1:  return !z;
      4'd2:  return c;        4'd3:  return !c;
      4'd4:  return l;        4'd5:  return !l;
      4'd6:  return n;        4'd7:  return !n;
      4'd8:  return fl;       4'd9:  return !fl;
      4'd10: return !l && !z; 4'd11: return l || z;
      4'd12: return !n && !z; 4'd13: return n || z;
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [4:0] ref_next();
    logic [4:0] alu;
    alu = {carry_i, low_i, overflow_i, zero_i, negative_i};
    if (psr_load_i) return psr_din_i;
    if (flag_we_i)  return (flag_mask_i & alu) | (~flag_mask_i & psr_m);
    return psr_m;
  endfunction

  task automatic idle_inputs();
    reset_i = 0; carry_i = 0; low_i = 0; overflow_i = 0; zero_i = 0; negative_i = 0;
    flag_we_i = 0; flag_mask_i = 0; psr_load_i = 0; psr_din_i = 0;
    cond_valid_i = 0; cond_code_i = 0;
  endtask

  // Advance one clock with the currently driven inputs; exp_override >= 0 pushes
  // a literal expected result instead of the reference one.
  task automatic tick(input int exp_override = -1);
    logic [4:0] nxt;
    bit         e;
    nxt = ref_next();
    e   = (exp_override >= 0) ? exp_override[0] : ref_cond(cond_code_i, nxt);
    @(posedge clk_i);
    if (reset_i) psr_m = 5'b0;
    else begin
      psr_m = nxt;
      if (cond_valid_i) sb_q.push_back(e);
    end
    #1;
  endtask

  // Scoreboard monitor: every expected result must appear exactly one cycle later.
  always @(negedge clk_i) begin
    if (cond_done_o === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL cond_unexpected: cond_done=1 with no pending request at %0t", $time);
      end else begin
        bit e;
        e = sb_q.pop_front();
        if (cond_true_o !== e) begin
          errors++;
          $display("FAIL cond_result: got %b expected %b at %0t", cond_true_o, e, $time);
        end
      end
    end else if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL cond_missing: cond_done=%b with %0d pending at %0t", cond_done_o, sb_q.size(), $time);
      sb_q.delete();
    end
  end

  task automatic test_reset();
    idle_inputs();
    reset_i = 1; flag_we_i = 1; flag_mask_i = 5'b11111;
    {carry_i, low_i, overflow_i, zero_i, negative_i} = 5'b11111;
    cond_valid_i = 1; cond_code_i = 4'hE;
    tick(); tick();
    checks++; if (psr_o !== 5'b0) begin errors++; $display("FAIL reset_psr: got %b expected 00000", psr_o); end
    checks++; if (cond_done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", cond_done_o); end
    checks++; if (cond_true_o !== 1'b0) begin errors++; $display("FAIL reset_true: got %b expected 0", cond_true_o); end
    idle_inputs();
  endtask

  task automatic test_masked_update();
    idle_inputs();
    flag_we_i = 1; flag_mask_i = 5'b01011;
    {carry_i, low_i, overflow_i, zero_i, negative_i} = 5'b11101;
    tick();
    idle_inputs();
    checks++; if (psr_o !== 5'b01001) begin errors++; $display("FAIL masked_psr: got %b expected 01001", psr_o); end
    checks++; if (carry_q_o !== 1'b0) begin errors++; $display("FAIL masked_carry: got %b expected 0", carry_q_o); end
  endtask

  task automatic test_forwarding();
    idle_inputs(); reset_i = 1; tick();
    idle_inputs();
    flag_we_i = 1; flag_mask_i = 5'b01011; zero_i = 1;
    cond_valid_i = 1; cond_code_i = 4'h0;
    tick(1);
    idle_inputs();
    checks++; if (cond_done_o !== 1'b1) begin errors++; $display("FAIL fwd_done: got %b expected 1", cond_done_o); end
    checks++; if (cond_true_o !== 1'b1) begin errors++; $display("FAIL fwd_true: got %b expected 1", cond_true_o); end
    checks++; if (psr_o !== 5'b00010) begin errors++; $display("FAIL fwd_psr: got %b expected 00010", psr_o); end
  endtask

  task automatic test_sweep();
    logic [15:0] exp_vec;
    int          done_cnt;
    exp_vec = 16'b1001100101010110; // bit 15 = code 0
    done_cnt = 0;
    idle_inputs();
    psr_load_i = 1; psr_din_i = 5'b01010;
    tick();
    idle_inputs();
    for (int k = 0; k < 16; k++) begin
      cond_valid_i = 1; cond_code_i = 4'(k);
      tick(int'(exp_vec[15-k]));
      if (cond_done_o === 1'b1) done_cnt++;
    end
    idle_inputs();
    checks++; if (done_cnt != 16) begin errors++; $display("FAIL sweep_done_run: got %0d expected 16", done_cnt); end
    tick();
    checks++; if (cond_done_o !== 1'b0) begin errors++; $display("FAIL sweep_done_end: got %b expected 0", cond_done_o); end
  endtask

  task automatic test_priority();
    idle_inputs();
    psr_load_i = 1; psr_din_i = 5'b11111;
    tick();
    psr_din_i = 5'b00100; flag_we_i = 1; flag_mask_i = 5'b11111;
    tick();
    idle_inputs();
    checks++; if (psr_o !== 5'b00100) begin errors++; $display("FAIL prio_psr: got %b expected 00100", psr_o); end
    checks++; if (carry_q_o !== 1'b0) begin errors++; $display("FAIL prio_carry: got %b expected 0", carry_q_o); end
  endtask

  task automatic test_carry_hold();
    logic [4:0] snap;
    idle_inputs();
    flag_we_i = 1; flag_mask_i = 5'b10000; carry_i = 1;
    cond_valid_i = 1; cond_code_i = 4'h2;
    checks++; if (carry_q_o !== 1'b0) begin errors++; $display("FAIL carry_early: got %b expected 0", carry_q_o); end
    tick(1);
    idle_inputs();
    checks++; if (carry_q_o !== 1'b1) begin errors++; $display("FAIL carry_set: got %b expected 1", carry_q_o); end
    snap = psr_o;
    checks++; if (snap !== 5'b10100) begin errors++; $display("FAIL carry_psr: got %b expected 10100", snap); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (psr_o !== 5'b10100 || carry_q_o !== 1'b1) begin errors++; $display("FAIL hold_psr: got %b/%b expected 10100/1", psr_o, carry_q_o); end
      checks++; if (cond_done_o !== 1'b0) begin errors++; $display("FAIL hold_done: got %b expected 0", cond_done_o); end
      checks++; if (cond_true_o !== 1'b1) begin errors++; $display("FAIL hold_true: got %b expected 1", cond_true_o); end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 200; k++) begin
      idle_inputs();
      psr_load_i   = ($urandom_range(0, 7) == 0);
      psr_din_i    = 5'($urandom_range(0, 31));
      flag_we_i    = $urandom_range(0, 1) == 1;
      flag_mask_i  = 5'($urandom_range(0, 31));
      {carry_i, low_i, overflow_i, zero_i, negative_i} = 5'($urandom_range(0, 31));
      cond_valid_i = $urandom_range(0, 2) != 0;
      cond_code_i  = 4'($urandom_range(0, 15));
      tick();
      checks++; if (psr_o !== psr_m || carry_q_o !== psr_m[4]) begin errors++; $display("FAIL rand_psr: got %b/%b expected %b", psr_o, carry_q_o, psr_m); end
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_masked_update();
    test_forwarding();
    test_sweep();
    test_priority();
    test_carry_hold();
    test_random();
    @(negedge clk_i); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
